// File: rtl/addr_range_decode.sv
// Registered address/ID range decoder.
// An address is mapped to an output index through a run-time rule table.
// Each rule is either a [start, end) range or a NAPOT base/mask pair.
// The decode result is registered, so it appears one cycle after the inputs.

// Single-rule matcher, instantiated once per rule table entry.
module addr_range_rule_match #(
    parameter int unsigned AddrWidth = 32,
    parameter bit          Napot     = 1'b0
) (
    input  logic [AddrWidth-1:0] addr,
    input  logic [AddrWidth-1:0] start_addr,  // NAPOT base
    input  logic [AddrWidth-1:0] end_addr,    // NAPOT mask
    output logic                 hit
);

    // end_addr == 0 means "up to the top of the address space"; the
    // comparisons are unsigned at full width, so start > end never hits.
    always_comb begin
        hit = 1'b0;
        if (Napot) begin
            hit = ((addr ^ start_addr) & end_addr) == '0;
        end else begin
            hit = (addr >= start_addr) &&
                  ((addr < end_addr) || (end_addr == '0));
        end
    end

endmodule

module addr_range_decode #(
    parameter  int unsigned NoIndices = 2,
    parameter  int unsigned NoRules   = 1,
    parameter  int unsigned AddrWidth = 32,
    parameter  bit          Napot     = 1'b0,
    localparam int unsigned IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1,
    localparam int unsigned RuleWidth = IdxWidth + 2 * AddrWidth
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [AddrWidth-1:0]         addr_i,
    input  logic [NoRules*RuleWidth-1:0] addr_map_i,
    input  logic [IdxWidth-1:0]          default_idx_i,
    input  logic                         en_default_idx_i,
    output logic [IdxWidth-1:0]          idx_o,
    output logic                         dec_valid_o,
    output logic                         dec_error_o
);

    // Packed MSB-to-LSB as {idx, start/base, end/mask}; rule i at i*RuleWidth.
    typedef struct packed {
        logic [IdxWidth-1:0]  idx;
        logic [AddrWidth-1:0] start_addr;
        logic [AddrWidth-1:0] end_addr;
    } rule_t;

    rule_t [NoRules-1:0] rules;
    logic  [NoRules-1:0] rule_hit;
    logic                match;
    logic [IdxWidth-1:0] match_idx;

    assign rules = addr_map_i;

    for (genvar g = 0; g < NoRules; g++) begin : g_rule
        addr_range_rule_match #(
            .AddrWidth (AddrWidth),
            .Napot     (Napot)
        ) u_match (
            .addr       (addr_i),
            .start_addr (rules[g].start_addr),
            .end_addr   (rules[g].end_addr),
            .hit        (rule_hit[g])
        );
    end

    // Ascending scan: the highest-numbered matching rule overwrites earlier hits.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        for (int i = 0; i < NoRules; i++) begin
            if (rule_hit[i]) begin
                match     = 1'b1;
                match_idx = rules[i].idx;
            end
        end
    end

    // Output register: match, default on miss, or error (index forced to 0).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_o       <= '0;
            dec_valid_o <= 1'b0;
            dec_error_o <= 1'b0;
        end else if (match) begin
            idx_o       <= match_idx;
            dec_valid_o <= 1'b1;
            dec_error_o <= 1'b0;
        end else if (en_default_idx_i) begin
            idx_o       <= default_idx_i;
            dec_valid_o <= 1'b1;
            dec_error_o <= 1'b0;
        end else begin
            idx_o       <= '0;
            dec_valid_o <= 1'b0;
            dec_error_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_addr_range_decode.sv
// Scoreboard bench for addr_range_decode: one range-mode and one NAPOT-mode
// instance share address and default inputs, each with its own rule table.
module tb_addr_range_decode;

    localparam int AW = 8;
    localparam int NI = 4;
    localparam int NR = 3;
    localparam int IW = 2;
    localparam int RW = IW + 2 * AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [AW-1:0]    addr;
    logic [NR*RW-1:0] map_r, map_n;
    logic [IW-1:0]    def_idx;
    logic             en_def;
    logic [IW-1:0]    idx_r, idx_n;
    logic             vld_r, err_r, vld_n, err_n;

    addr_range_decode #(.NoIndices(NI), .NoRules(NR), .AddrWidth(AW), .Napot(1'b0)) u_rng (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .addr_map_i(map_r),
        .default_idx_i(def_idx), .en_default_idx_i(en_def),
        .idx_o(idx_r), .dec_valid_o(vld_r), .dec_error_o(err_r));

    addr_range_decode #(.NoIndices(NI), .NoRules(NR), .AddrWidth(AW), .Napot(1'b1)) u_nap (
        .clk_i(clk), .rst_ni(rst_n), .addr_i(addr), .addr_map_i(map_n),
        .default_idx_i(def_idx), .en_default_idx_i(en_def),
        .idx_o(idx_n), .dec_valid_o(vld_n), .dec_error_o(err_n));

    // Rule tables as plain integers: range {idx,start,end}, NAPOT {idx,base,mask}.
    int r_idx[NR], r_s[NR], r_e[NR];
    int n_idx[NR], n_b[NR], n_m[NR];

    typedef struct {
        int idx_r; int v_r; int e_r;
        int idx_n; int v_n; int e_n;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    function automatic logic [NR*RW-1:0] pack(input int ix[NR], input int a[NR], input int b[NR]);
        logic [NR*RW-1:0] p;
        p = '0;
        for (int i = 0; i < NR; i++)
            p[i*RW +: RW] = {IW'(ix[i]), AW'(a[i]), AW'(b[i])};
        return p;
    endfunction

    // Reference decode straight from the rule definitions: last matching rule wins.
    function automatic void ref_decode(input bit napot, input int a, input int ix[NR],
                                       input int p[NR], input int q[NR], input bit ed,
                                       input int di, output int o_idx, output int o_v,
                                       output int o_e);
        int win;
        bit m;
        win = -1;
        for (int i = 0; i < NR; i++) begin
            if (napot) m = ((a & q[i]) == (p[i] & q[i]));
            else       m = (a >= p[i]) && (q[i] == 0 || a < q[i]);
            if (m) win = i;
        end
        if (win >= 0)  begin o_idx = ix[win]; o_v = 1; o_e = 0; end
        else if (ed)   begin o_idx = di;      o_v = 1; o_e = 0; end
        else           begin o_idx = 0;       o_v = 0; o_e = 1; end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; the expected result is queued at the sampling edge.
    task automatic drive(input int a);
        exp_t x;
        addr  = AW'(a);
        map_r = pack(r_idx, r_s, r_e);
        map_n = pack(n_idx, n_b, n_m);
        @(posedge clk);
        if (!rst_n) begin
            x = '{0, 0, 0, 0, 0, 0};
        end else begin
            ref_decode(1'b0, a, r_idx, r_s, r_e, en_def, int'(def_idx), x.idx_r, x.v_r, x.e_r);
            ref_decode(1'b1, a, n_idx, n_b, n_m, en_def, int'(def_idx), x.idx_n, x.v_n, x.e_n);
        end
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: every registered result is compared one cycle after its inputs.
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            chk("rng_idx",   int'(idx_r), x.idx_r);
            chk("rng_valid", int'(vld_r), x.v_r);
            chk("rng_error", int'(err_r), x.e_r);
            chk("nap_idx",   int'(idx_n), x.idx_n);
            chk("nap_valid", int'(vld_n), x.v_n);
            chk("nap_error", int'(err_n), x.e_n);
            checks++;
            if (vld_r && err_r) begin
                errors++;
                $display("FAIL rng_excl: valid and error both 1");
            end
        end
    end

    task automatic set_rng(input int i0, input int s0, input int e0, input int i1, input int s1,
                           input int e1, input int i2, input int s2, input int e2);
        r_idx = '{i0, i1, i2}; r_s = '{s0, s1, s2}; r_e = '{e0, e1, e2};
    endtask

    initial begin
        rst_n = 1'b0; en_def = 1'b0; def_idx = '0; addr = '0;
        set_rng(1, 'h00, 'h10, 2, 'h10, 'h20, 3, 'h20, 'h00);
        n_idx = '{0, 2, 0}; n_b = '{'h00, 'h40, 'h00}; n_m = '{'hFF, 'hC0, 'hFF};
        map_r = '0; map_n = '0;
        @(negedge clk);

        // Reset held with a matching address, then the first decode after release.
        drive(5); drive(5);
        rst_n = 1'b1;
        drive(5);

        // Range table with end=0 wrap.
        drive('h0F); drive('h10); drive('hFF); drive('h00); drive('h1F); drive('h20);

        // Overlap priority; rule 2 is start>end so never matches.
        set_rng(1, 'h00, 'h40, 2, 'h20, 'h30, 0, 'hFF, 'h01);
        drive('h25); drive('h35); drive('hFF);

        // Miss handling with and without default.
        set_rng(1, 'h10, 'h20, 0, 'hFF, 'h01, 0, 'hFF, 'h01);
        drive('h30);
        en_def = 1'b1; def_idx = 2'd3;
        drive('h30);
        en_def = 1'b0;

        // NAPOT hit and miss (range table above is exercised too).
        drive('h7F); drive('h80); drive('h40);

        // Back-to-back sweep against the first range table.
        set_rng(1, 'h00, 'h10, 2, 'h10, 'h20, 3, 'h20, 'h00);
        for (int a = 0; a < 'h40; a++) drive(a);

        // Random tables, addresses biased toward edges, one mid-stream reset.
        for (int it = 0; it < 400; it++) begin
            int sel;
            int a;
            if (it % 16 == 0) begin
                for (int i = 0; i < NR; i++) begin
                    r_idx[i] = int'($urandom_range(0, NI - 1));
                    r_s[i]   = int'($urandom_range(0, 255));
                    r_e[i]   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
                    n_idx[i] = int'($urandom_range(0, NI - 1));
                    n_b[i]   = int'($urandom_range(0, 255));
                    n_m[i]   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
                end
            end
            en_def  = 1'($urandom_range(0, 1));
            def_idx = IW'($urandom_range(0, NI - 1));
            rst_n   = (it == 200) ? 1'b0 : 1'b1;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       a = 0;
                1:       a = 255;
                2:       a = r_s[$urandom_range(0, NR - 1)];
                3:       a = (r_e[0] - 1) & 'hFF;
                default: a = int'($urandom_range(0, 255));
            endcase
            drive(a);
        end

        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
